// File: rtl/counter_sweep_ctrl.sv
// Triangle-sweep sequencer for a shared up/down counter.
// Ports: clk/rst, start/abort, limits, n_sweeps, cnt_in -> cnt_updown/cnt_rst, busy/done/err/sweep_cnt.
module counter_sweep_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] lo_limit,
  input  logic [WIDTH-1:0] hi_limit,
  input  logic [7:0]       n_sweeps,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             cnt_updown,
  output logic             cnt_rst,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       sweep_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN,
    DONE
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] exp_cnt;
  logic [7:0]       sweep_nxt;
  logic             mismatch;

  assign sweep_nxt = sweep_cnt + 8'd1;
  assign mismatch  = (cnt_in != exp_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lo_q       <= '0;
      hi_q       <= '0;
      exp_cnt    <= '0;
      cnt_rst    <= 1'b1;
      cnt_updown <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      sweep_cnt  <= '0;
    end else begin
      done <= 1'b0;
      // Shadow of the counter: follows the controls it
      // saw on this edge.
      if (cnt_rst)
        exp_cnt <= '0;
      else if (cnt_updown)
        exp_cnt <= exp_cnt + ONE;
      else
        exp_cnt <= exp_cnt - ONE;

      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            if (lo_limit < hi_limit) begin
              lo_q       <= lo_limit;
              hi_q       <= hi_limit;
              sweep_cnt  <= '0;
              err        <= 1'b0;
              cnt_rst    <= 1'b0;
              cnt_updown <= 1'b1;
              busy       <= 1'b1;
              state      <= UP;
            end else begin
              err <= 1'b1;
            end
          end
        end
        UP: begin
          if (abort || mismatch) begin
            if (!abort) err <= 1'b1;
            cnt_rst    <= 1'b1;
            cnt_updown <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (cnt_in == hi_q - ONE) begin
            // Reverse one early: the counter acts
            // a cycle after us, so it peaks at hi.
            cnt_updown <= 1'b0;
            state      <= DOWN;
          end
        end
        DOWN: begin
          if (abort || mismatch) begin
            if (!abort) err <= 1'b1;
            cnt_rst    <= 1'b1;
            cnt_updown <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (cnt_in == lo_q + ONE) begin
            sweep_cnt <= sweep_nxt;
            if (n_sweeps != 8'd0 &&
                sweep_nxt == n_sweeps) begin
              cnt_rst <= 1'b1;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              cnt_updown <= 1'b1;
              state      <= UP;
            end
          end
        end
        DONE: begin
          cnt_rst    <= 1'b1;
          cnt_updown <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/counter_sweep_ctrl.md
# counter_sweep_ctrl

Sequencer for the shared WIDTH-bit up/down counter. It steers the counter's direction and reset so the count sweeps as a triangle wave between programmable limits for a programmed number of sweeps. It checks the returned count against an internal model and reports completion and errors. It sits beside the counter: it drives the counter's `updown`/`rst` and reads back its `out`.

## Interface
- WIDTH, 8, counter width; must match the counter instance
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  stop the run and return to IDLE
- lo_limit  in  WIDTH  lower turnaround value; latched on an accepted start
- hi_limit  in  WIDTH  upper turnaround value; latched on an accepted start
- n_sweeps  in  8  number of sweeps to run; 0 = run until abort
- cnt_in  in  WIDTH  counter `out`
- cnt_updown  out  1  to counter `updown` (1 = count up)
- cnt_rst  out  1  to counter `rst`
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at normal completion
- err  out  1  sticky error flag; cleared by the next accepted start
- sweep_cnt  out  8  number of completed sweeps

## Operation
- Counter behaviour: on each edge, `out` is cleared to 0 if `rst` is high; otherwise it changes by +1 or -1 according to `updown`. The counter never holds.
- All outputs are registered. Reset values: `cnt_rst`=1, `cnt_updown`=1, `busy`=0, `done`=0, `err`=0, `sweep_cnt`=0, state=IDLE.
- States: IDLE, UP, DOWN, DONE.
- IDLE: `cnt_rst`=1, which holds the counter at 0.
  - `start`&&!`abort` with lo<hi: latch the limits, clear `sweep_cnt` and `err`, set `cnt_rst`<=0 and `cnt_updown`<=1, go to UP.
  - `start` with lo>=hi: `err`<=1, stay in IDLE.
  - `start`&&`abort` together: stay in IDLE, no effect.
- UP: when `cnt_in`==hi-1, set `cnt_updown`<=0 and go to DOWN. The counter peaks at hi.
- DOWN: when `cnt_in`==lo+1, a sweep completes.
  - `sweep_cnt`<=`sweep_cnt`+1, wrapping 255->0.
  - If `n_sweeps`!=0 and the incremented value equals `n_sweeps`: go to DONE with `cnt_rst`<=1 and `done`<=1.
  - Otherwise set `cnt_updown`<=1 and go to UP.
  - Either way the counter reaches lo on that edge.
- DONE: lasts one cycle; `cnt_in`=lo while `done`=1. Next edge: `done`<=0, go to IDLE. `cnt_rst` stays 1 and `cnt_updown` returns to 1.
- The first sweep ramps up from 0, not from lo. Later sweeps run lo..hi..lo.
- Model check:
  - Expected count `exp` is 0 whenever `cnt_rst` was high on the previous edge; otherwise it moves ±1 following `cnt_updown`, wrapping mod 2^WIDTH.
  - In UP or DOWN, `cnt_in`!=`exp` sets `err`<=1, `cnt_rst`<=1 and state<=IDLE on the next edge, with no `done`.
- abort in UP, DOWN or DONE: next edge goes to IDLE with `cnt_rst`<=1, `cnt_updown`<=1, `done`<=0. `err` and `sweep_cnt` are unchanged.
- abort has priority over turnaround and completion in the same cycle.
- `start` is ignored while `busy`=1.
- `rst` mid-run restores every reset value on the next edge, regardless of state.

## Timing
- The counter acts on `cnt_rst`/`cnt_updown` at the edge after they are registered.
- With `start` accepted in cycle t:
  - `busy`=1 from t+1.
  - `cnt_in`=k in cycle t+1+k, until the first reversal.
  - First peak at hi in cycle t+1+hi.
- Each subsequent sweep lasts 2*(hi-lo) cycles, lower turnaround to lower turnaround.
- hi-lo=1 is legal: the counter alternates lo, hi every cycle.
- Error, abort and done-to-IDLE each take effect 1 cycle after the triggering condition. `cnt_in` reads 0 one cycle after `cnt_rst` rises.

## Test plan
- Normal run: lo=2, hi=5, n=2, start at cycle 0.
  - `cnt_in` in cycles 1..16 is 0,1,2,3,4,5,4,3,2,3,4,5,4,3,2,0.
  - `done`=1 only in cycle 15.
  - `sweep_cnt`=2 from cycle 15.
  - `busy` falls in cycle 16.
- Bad config: lo=5, hi=5, start.
  - `err`=1 next cycle, `busy` stays 0.
  - A following start with lo=0, hi=3 clears `err` and runs.
- Minimum span: lo=0, hi=1, n=3.
  - Counter sequence 0,1,0,1,0,1,0 (the final 0 is in DONE).
  - `done` pulses once; `sweep_cnt`=3.
- Continuous and abort: n=0, lo=1, hi=4.
  - Runs past 300 sweeps, with `sweep_cnt` wrapping 255->0.
  - abort in DOWN: next cycle IDLE, `cnt_rst`=1, `done` never asserted.
- Model mismatch: the bench forces `cnt_in` off by one in UP.
  - `err`=1 and `busy`=0 next cycle.
  - `cnt_in` holds 0 afterwards.
- Reset and collisions:
  - `rst` during UP gives all reset values next cycle.
  - `start`&&`abort` in IDLE has no effect.
  - `start` while busy has no effect.
